sop_sweep_ctrl: RTL and testbench
=================================

SOP_SWEEP_CTRL -- requirements
Module: sop_sweep_ctrl

Interface
REQ-001 Parameter: DWELL, default 10, clock cycles each input vector is held before y is sampled (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin an 8-vector sweep; honoured only in IDLE.
REQ-005 abort  input  1  terminate the sweep in progress; ignored in IDLE.
REQ-006 exp_mask  input  8  expected truth table, bit i = expected y for vector i; latched on accepted start.
REQ-007 a, b, c  output  1 each  registered drive to the SOP datapath; a=idx[2], b=idx[1], c=idx[0].
REQ-008 y  input  1  SOP datapath output under test.
REQ-009 busy  output  1  high in APPLY and SAMPLE.
REQ-010 done  output  1  one-cycle pulse on sweep completion.
REQ-011 pass  output  1  high when the captured table equals the latched exp_mask; valid from done until next accepted start.
REQ-012 tt  output  8  captured truth table, bit i = y sampled for vector i.
REQ-013 mismatch  output  8  tt XOR latched exp_mask; valid with pass.

Function
REQ-014 FSM states: IDLE, APPLY, SAMPLE, DONE; encoding is an implementation choice.
REQ-015 IDLE: start=1 -> APPLY, idx<=0, dwell count<=0, tt/mismatch/pass<=0, exp_mask latched.
REQ-016 APPLY: a,b,c reflect idx; count increments every cycle; at count==DWELL-1 -> SAMPLE.
REQ-017 SAMPLE: tt[idx]<=y; idx==7 -> DONE, else idx<=idx+1, count<=0, -> APPLY.
REQ-018 DONE: done=1 for exactly this cycle, pass and mismatch registered from final tt, -> IDLE.
REQ-019 Vector order fixed 0..7; no wrap-around; idx never exceeds 7.
REQ-020 Each vector occupies DWELL+1 cycles; done is high in the cycle beginning 8*(DWELL+1) rising edges after the edge that accepts start.
REQ-021 start while busy or in DONE is ignored; start and abort together in IDLE: start wins.
REQ-022 abort in APPLY/SAMPLE -> IDLE next edge; no done pulse; pass=0; tt keeps bits captured so far; a,b,c<=0.
REQ-023 abort in the same cycle as the SAMPLE of vector 7 takes priority; no done pulse.
REQ-024 a,b,c are 0 in IDLE and DONE.
REQ-025 exp_mask changes after accepted start do not affect pass or mismatch.

Reset
REQ-026 rst_n low forces IDLE immediately: a,b,c,busy,done,pass=0, tt=0, mismatch=0, idx=0, count=0.
REQ-027 Reset mid-sweep discards the sweep; no done pulse after rst_n deasserts.
REQ-028 First start is accepted on the first rising edge with rst_n high.

Structure
REQ-029 Shared package/header holds the state encodings, vector count (8), and the DWELL default.
REQ-030 One sub-module, sop_sweep_dwell: a counter with clear, enable, and terminal flag (count==DWELL-1).
REQ-031 The SOP datapath is external; the bench connects a,b,c,y to sopexample.

Verification
REQ-032 DWELL=2, y = a&b | c, exp_mask=8'hEA, start -> tt=8'hEA, pass=1, mismatch=8'h00, done 24 edges after start.
REQ-033 Same datapath, exp_mask=8'hE8 -> pass=0, mismatch=8'h02, done timing unchanged.
REQ-034 DWELL=1, start, abort during vector 3 APPLY -> busy=0 next edge, no done, a,b,c=0, tt[2:0]=captured bits, tt[7:3]=0.
REQ-035 start pulsed again at vector 5 -> ignored; sweep completes once, single done pulse.
REQ-036 rst_n low for 1 cycle mid-sweep (vector 4) -> all outputs 0 asynchronously; no done pulse; fresh start completes normally.
REQ-037 DWELL=1: a,b,c follow idx 0..7 each held 2 cycles; start and abort asserted together in IDLE -> sweep starts.

Source files
------------

// File: rtl/sop_sweep_ctrl_pkg.sv
// rtl/sop_sweep_ctrl_pkg.sv - shared state encoding and sizing for the SOP sweep controller
package sop_sweep_ctrl_pkg;

  localparam int NUM_VEC       = 8;
  localparam int DWELL_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sop_sweep_dwell.sv
// rtl/sop_sweep_dwell.sv - dwell counter with clear, enable and last-cycle flag
module sop_sweep_dwell #(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // clear has priority over advance; otherwise the count holds
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == LAST);

endmodule

// File: rtl/sopexample.sv
// rtl/sopexample.sv - sum-of-products datapath y = a&b | c driven by the sweep controller
module sopexample (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | c;

endmodule

// File: rtl/sop_sweep_ctrl.sv
// rtl/sop_sweep_ctrl.sv - sweeps a,b,c through vectors 0..7 and captures the SOP truth table
module sop_sweep_ctrl
  import sop_sweep_ctrl_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] exp_mask,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] tt,
  output logic [7:0] mismatch
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] tt_q, tt_d;
  logic [7:0] mm_q, mm_d;
  logic       pass_q, pass_d;
  logic       dwell_clr;
  logic       dwell_en;
  logic       dwell_term;

  sop_sweep_dwell #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (dwell_clr),
    .en   (dwell_en),
    .term (dwell_term)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: abort beats sampling, including the final vector
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        if (abort)           state_d = ST_IDLE;
        else if (dwell_term) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)                 state_d = ST_IDLE;
        else if (idx_q == LAST_IDX) state_d = ST_DONE;
        else                       state_d = ST_APPLY;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath updates and the registered drive to the SOP inputs
  always_comb begin
    idx_d     = idx_q;
    exp_d     = exp_q;
    tt_d      = tt_q;
    mm_d      = mm_q;
    pass_d    = pass_q;
    dwell_clr = 1'b0;
    dwell_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d     = '0;
          exp_d     = exp_mask;
          tt_d      = '0;
          mm_d      = '0;
          pass_d    = 1'b0;
          dwell_clr = 1'b1;
        end
      end
      ST_APPLY: begin
        if (abort) begin
          idx_d     = '0;
          pass_d    = 1'b0;
          dwell_clr = 1'b1;
        end else begin
          dwell_en = 1'b1;
        end
      end
      ST_SAMPLE: begin
        dwell_clr = 1'b1;
        if (abort) begin
          idx_d  = '0;
          pass_d = 1'b0;
        end else begin
          tt_d[idx_q] = y;
          if (idx_q == LAST_IDX) begin
            // verdict is registered on entry to DONE so it is valid with the done pulse
            mm_d   = tt_d ^ exp_q;
            pass_d = (tt_d == exp_q);
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        idx_d = '0;
      end
      default: begin
        idx_d = '0;
      end
    endcase
    abc_d = ((state_d == ST_APPLY) || (state_d == ST_SAMPLE)) ? idx_d : 3'd0;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      abc_q  <= '0;
      exp_q  <= '0;
      tt_q   <= '0;
      mm_q   <= '0;
      pass_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      abc_q  <= abc_d;
      exp_q  <= exp_d;
      tt_q   <= tt_d;
      mm_q   <= mm_d;
      pass_q <= pass_d;
    end
  end

  // status outputs decoded from the state register
  always_comb begin
    busy = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
    done = (state_q == ST_DONE);
  end

  assign a        = abc_q[2];
  assign b        = abc_q[1];
  assign c        = abc_q[0];
  assign pass     = pass_q;
  assign tt       = tt_q;
  assign mismatch = mm_q;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// tb/tb_sop_sweep_ctrl.sv - self-checking bench for sop_sweep_ctrl at DWELL=2 and DWELL=1
module tb_sop_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1, abort0, abort1;
  logic [7:0] exp0, exp1;
  logic       a0, b0, c0, a1, b1, c1;
  logic       y0, y1, sy0, sy1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] tt0, tt1, mm0, mm1;
  logic [7:0] tab0, tab1;
  logic [1:0] use_sop;

  int total = 0;
  int bad   = 0;

  sop_sweep_ctrl #(.DWELL(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .exp_mask(exp0),
    .a(a0), .b(b0), .c(c0), .y(y0), .busy(busy0), .done(done0), .pass(pass0),
    .tt(tt0), .mismatch(mm0)
  );

  sop_sweep_ctrl #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .exp_mask(exp1),
    .a(a1), .b(b1), .c(c1), .y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .tt(tt1), .mismatch(mm1)
  );

  sopexample u_sop0 (.a(a0), .b(b0), .c(c0), .y(sy0));
  sopexample u_sop1 (.a(a1), .b(b1), .c(c1), .y(sy1));

  assign y0 = use_sop[0] ? sy0 : tab0[{a0, b0, c0}];
  assign y1 = use_sop[1] ? sy1 : tab1[{a1, b1, c1}];

  function automatic logic [2:0] g_abc(input int k);
    return (k == 0) ? {a0, b0, c0} : {a1, b1, c1};
  endfunction
  function automatic logic g_busy(input int k);
    return (k == 0) ? busy0 : busy1;
  endfunction
  function automatic logic g_done(input int k);
    return (k == 0) ? done0 : done1;
  endfunction
  function automatic logic g_pass(input int k);
    return (k == 0) ? pass0 : pass1;
  endfunction
  function automatic logic [7:0] g_tt(input int k);
    return (k == 0) ? tt0 : tt1;
  endfunction
  function automatic logic [7:0] g_mm(input int k);
    return (k == 0) ? mm0 : mm1;
  endfunction

  // truth table of a&b | c written straight from the equation, bit i = vector i
  function automatic logic [7:0] sop_table();
    logic [7:0] t;
    logic [2:0] v;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      t[i] = (v[2] & v[1]) | v[0];
    end
    return t;
  endfunction

  task automatic drive(input int k, input logic s, input logic ab);
    if (k == 0) begin start0 = s; abort0 = ab; end
    else        begin start1 = s; abort1 = ab; end
  endtask

  task automatic set_exp(input int k, input logic [7:0] e);
    if (k == 0) exp0 = e; else exp1 = e;
  endtask

  task automatic set_src(input int k, input logic us, input logic [7:0] t);
    use_sop[k] = us;
    if (k == 0) tab0 = t; else tab1 = t;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // one sweep, called at a falling edge; checks the a,b,c / busy timeline against the
  // vector schedule (each vector DWELL+1 cycles, idle after abort or after the done cycle)
  task automatic sweep(input int k, input logic us, input logic [7:0] tab, input logic [7:0] e,
                       input int ab_t, input int rs_t, input logic both, input string nm,
                       output int done_t, output int ndone, output logic [7:0] tt_o,
                       output logic pass_o, output logic [7:0] mm_o);
    int dw, n, seq_bad;
    logic [2:0] x_abc;
    logic x_busy;
    dw = (k == 0) ? 2 : 1;
    n  = 8 * (dw + 1);
    set_src(k, us, tab);
    set_exp(k, e);
    drive(k, 1'b1, both);
    @(negedge clk);
    drive(k, 1'b0, 1'b0);
    set_exp(k, ~e);
    done_t  = -1;
    ndone   = 0;
    seq_bad = 0;
    for (int t = 0; t < n + 4; t++) begin
      if (ab_t >= 0 && t > ab_t) begin
        x_busy = 1'b0; x_abc = 3'd0;
      end else if (t < n) begin
        x_busy = 1'b1; x_abc = 3'(t / (dw + 1));
      end else begin
        x_busy = 1'b0; x_abc = 3'd0;
      end
      if (g_busy(k) !== x_busy || g_abc(k) !== x_abc) seq_bad++;
      if (g_done(k) === 1'b1) begin
        ndone++;
        if (done_t < 0) done_t = t;
      end
      drive(k, 1'(t == rs_t), 1'(t == ab_t));
      @(negedge clk);
    end
    drive(k, 1'b0, 1'b0);
    tt_o   = g_tt(k);
    pass_o = g_pass(k);
    mm_o   = g_mm(k);
    chk({nm, "_seq"}, 32'(seq_bad), 32'd0);
  endtask

  typedef struct {
    int         k;
    logic       us;
    logic [7:0] tab;
    logic [7:0] e;
    int         ab_t;
    int         rs_t;
    logic       both;
    logic [7:0] x_tt;
    logic       x_pass;
    logic [7:0] x_mm;
    logic       chk_mm;
    int         x_done;
  } vec_t;

  vec_t vecs[10];

  int         done_t, ndone, k, dw, n, ab, rs, x_done;
  logic [7:0] r_tt, r_mm, tab, e, cap, x_tt;
  logic       r_pass, us, both, x_pass;
  int         seen;

  initial begin
    rst_n = 1'b0;
    start0 = 0; start1 = 0; abort0 = 0; abort1 = 0;
    exp0 = '0; exp1 = '0; tab0 = '0; tab1 = '0; use_sop = 2'b11;

    //          k us tab    exp    ab  rs  both tt     pass mm    chkmm done
    vecs[0] = '{0, 1, 8'h00, 8'hEA, -1, -1, 0, 8'hEA, 1, 8'h00, 1, 24};
    vecs[1] = '{0, 1, 8'h00, 8'hE8, -1, -1, 0, 8'hEA, 0, 8'h02, 1, 24};
    vecs[2] = '{1, 1, 8'h00, 8'hEA,  6, -1, 0, 8'h02, 0, 8'h00, 0, -1};
    vecs[3] = '{1, 1, 8'h00, 8'hEA, -1, 10, 0, 8'hEA, 1, 8'h00, 1, 16};
    vecs[4] = '{1, 1, 8'h00, 8'hEA, -1, -1, 1, 8'hEA, 1, 8'h00, 1, 16};
    vecs[5] = '{1, 0, 8'h5C, 8'h5D, -1, 16, 0, 8'h5C, 0, 8'h01, 1, 16};
    vecs[6] = '{1, 1, 8'h00, 8'hEA, 15, -1, 0, 8'h6A, 0, 8'h00, 0, -1};
    vecs[7] = '{0, 0, 8'hFF, 8'h00, -1, -1, 0, 8'hFF, 0, 8'hFF, 1, 24};
    vecs[8] = '{0, 0, 8'h3C, 8'h3C,  0, -1, 0, 8'h00, 0, 8'h00, 0, -1};
    vecs[9] = '{0, 0, 8'h97, 8'h97,  3, -1, 0, 8'h01, 0, 8'h00, 0, -1};

    repeat (2) @(negedge clk);
    chk("rst_ctl0", 32'({a0, b0, c0, busy0, done0, pass0}), 32'd0);
    chk("rst_ctl1", 32'({a1, b1, c1, busy1, done1, pass1}), 32'd0);
    chk("rst_tt_mm", 32'({tt0, mm0, tt1, mm1}), 32'd0);

    // release reset and request start on the same falling edge: first rising edge accepts
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sweep(vecs[i].k, vecs[i].us, vecs[i].tab, vecs[i].e, vecs[i].ab_t, vecs[i].rs_t,
            vecs[i].both, $sformatf("vec%0d", i), done_t, ndone, r_tt, r_pass, r_mm);
      chk($sformatf("vec%0d_done_t", i), 32'(done_t), 32'(vecs[i].x_done));
      chk($sformatf("vec%0d_ndone", i), 32'(ndone), (vecs[i].x_done >= 0) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_tt", i), 32'(r_tt), 32'(vecs[i].x_tt));
      chk($sformatf("vec%0d_pass", i), 32'(r_pass), 32'(vecs[i].x_pass));
      if (vecs[i].chk_mm) chk($sformatf("vec%0d_mm", i), 32'(r_mm), 32'(vecs[i].x_mm));
    end

    // reset pulse in the middle of vector 4 at DWELL=1
    set_src(1, 1'b1, 8'h00);
    set_exp(1, 8'hEA);
    drive(1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("pre_rst_abc", 32'({busy1, a1, b1, c1}), 32'({1'b1, 3'd4}));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", 32'({a1, b1, c1, busy1, done1, pass1}), 32'd0);
    chk("rst_async_tt_mm", 32'({tt1, mm1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      if (done1 !== 1'b0 || busy1 !== 1'b0) seen++;
      @(negedge clk);
    end
    chk("rst_no_resume", 32'(seen), 32'd0);
    sweep(1, 1'b1, 8'h00, 8'hEA, -1, -1, 1'b0, "post_rst", done_t, ndone, r_tt, r_pass, r_mm);
    chk("post_rst_done_t", 32'(done_t), 32'd16);
    chk("post_rst_tt_pass", 32'({r_tt, r_pass, r_mm}), 32'({8'hEA, 1'b1, 8'h00}));

    // randomized sweeps against a schedule-level model
    for (int r = 0; r < 24; r++) begin
      k    = int'($urandom_range(0, 1));
      dw   = (k == 0) ? 2 : 1;
      n    = 8 * (dw + 1);
      us   = 1'($urandom_range(0, 3) == 0);
      tab  = us ? sop_table() : 8'($urandom);
      e    = ($urandom_range(0, 2) == 0) ? tab : 8'($urandom);
      both = 1'($urandom);
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      if (ab >= 0) rs = (ab > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, ab - 1)) : -1;
      else         rs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n)) : -1;
      if (ab < 0) begin
        x_tt = tab; x_pass = (tab == e); x_done = n;
      end else begin
        cap = '0;
        for (int v = 0; v < 8; v++) if (v * (dw + 1) + dw < ab) cap[v] = 1'b1;
        x_tt = tab & cap; x_pass = 1'b0; x_done = -1;
      end
      sweep(k, us, tab, e, ab, rs, both, $sformatf("rnd%0d", r), done_t, ndone, r_tt, r_pass, r_mm);
      chk($sformatf("rnd%0d_done_t", r), 32'(done_t), 32'(x_done));
      chk($sformatf("rnd%0d_ndone", r), 32'(ndone), (ab < 0) ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d_tt", r), 32'(r_tt), 32'(x_tt));
      chk($sformatf("rnd%0d_pass", r), 32'(r_pass), 32'(x_pass));
      if (ab < 0) chk($sformatf("rnd%0d_mm", r), 32'(r_mm), 32'(tab ^ e));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
